menu_sprite_fetch: RTL and testbench
====================================

# menu_sprite_fetch

Pixel-fetch stage placed directly upstream of the start-menu frame RAMs and downstream of the VGA controller. It converts the raster position (DrawX, DrawY) into a 19-bit RAM read address for a 160x75 menu image scaled 4x to 640x300. It selects which of two animation frames (Start_Menu_1 / Start_Menu_2 RAM) is shown, alternating on a frame-count timer. It also delay-aligns the in-sprite flag with the RAM's registered output and applies colour keying to produce the final menu RGB.

## Interface
Parameters:
- IMG_W, 160, source image width in texels
- IMG_H, 75, source image height in texels
- SCALE_SHIFT, 2, log2 of the screen-pixels-per-texel scale factor
- ORIGIN_X, 0, screen X of the image's top-left corner
- ORIGIN_Y, 90, screen Y of the image's top-left corner
- FRAME_HOLD, 30, number of video frames each animation frame is shown
- KEY_COLOR, 24'hFF0000, transparent colour in RAM data
- BG_COLOR, 24'h000000, colour output outside the image or on a key texel

Ports:
- Clk  in  1  system clock (50 MHz)
- Reset_n  in  1  asynchronous, active-low reset
- menu_active  in  1  menu screen is being displayed
- DrawX  in  10  current pixel column from the VGA controller
- DrawY  in  10  current pixel row from the VGA controller
- read_address  out  19  address to both menu frame RAMs (registered)
- frame_sel  out  1  0 = Menu_1 RAM data is used, 1 = Menu_2 RAM data is used
- ram_data_1  in  24  data_Out of the Menu_1 RAM (1-cycle registered read)
- ram_data_2  in  24  data_Out of the Menu_2 RAM
- menu_rgb  out  24  final menu pixel colour (registered)
- menu_rgb_valid  out  1  menu_rgb corresponds to a pixel inside the image and menu_active

## Operation
- In-box test: relX = DrawX − ORIGIN_X and relY = DrawY − ORIGIN_Y, both 10-bit unsigned. in_box = (DrawX ≥ ORIGIN_X) & (relX < IMG_W<<SCALE_SHIFT) & (DrawY ≥ ORIGIN_Y) & (relY < IMG_H<<SCALE_SHIFT) & menu_active.
- Address: tx = relX>>SCALE_SHIFT and ty = relY>>SCALE_SHIFT; addr = ty·IMG_W + tx.
  - For the default IMG_W, implement the multiply as (ty<<7)+(ty<<5); no multiplier is inferred.
  - Compute at 19 bits; the maximum is 11999.
- When in_box = 0, read_address is driven to 0.
- Animation FSM states: SHOW_A (frame_sel = 0) and SHOW_B (frame_sel = 1), with an 8-bit hold counter.
- Frame start event: the rising edge of (DrawX == 0 & DrawY == 0), detected against a registered copy. It fires exactly once per frame even though the position is held for two Clk cycles.
- On each frame start event while menu_active = 1:
  - If the counter equals FRAME_HOLD−1: the counter goes to 0 and the state toggles.
  - Otherwise the counter increments.
- menu_active = 0 forces SHOW_A and counter = 0 on the next Clk.
- frame_sel changes only on a frame start event, so there is no mid-frame tearing.
- Output colour: selected = frame_sel_d2 ? ram_data_2 : ram_data_1.
  - menu_rgb = (in_box_d2 & selected ≠ KEY_COLOR) ? selected : BG_COLOR.
  - menu_rgb_valid = in_box_d2.
  - frame_sel_d2 is frame_sel delayed so it matches the address that produced the data.

## Timing
- Cycle t: DrawX/DrawY sampled.
- t+1: read_address is valid, and in_box_d1 is registered.
- t+2: the RAM presents data_Out.
- t+3: menu_rgb and menu_rgb_valid are registered. Total latency is 3 Clk cycles from the position to the colour.
- The pipeline advances every Clk, with no stall or enable. Upstream holds each pixel for 2 Clk cycles, so consecutive identical outputs are expected.
- frame_sel updates 1 cycle after the frame start event.
- Reset (asynchronous assert, takes effect immediately regardless of Clk):
  - read_address = 0, frame_sel = 0, menu_rgb = 0, menu_rgb_valid = 0.
  - FSM in SHOW_A, counter = 0, all delay registers = 0, frame-start edge register = 0.
- Reset mid-frame: after deassertion, the first valid colour appears 3 cycles after the first sampled in-box position. The FSM restarts at SHOW_A.
- Boundaries:
  - DrawX = ORIGIN_X+639 is inside the image; DrawX = ORIGIN_X+640 is outside.
  - DrawY = ORIGIN_Y+299 is inside; ORIGIN_Y+300 is outside.
  - DrawX < ORIGIN_X must not wrap into the image (the compare is explicit, not relX underflow).

## Test plan
- Reset then release, menu_active = 1, DrawX = 0, DrawY = 90 -> read_address = 0 at t+1; menu_rgb = ram_data_1 and menu_rgb_valid = 1 at t+3. Before that, all outputs are 0.
- DrawX = 639, DrawY = 389 (defaults) -> read_address = 11999 at t+1. DrawX = 640 -> read_address = 0 and, 3 cycles later, menu_rgb = BG_COLOR with menu_rgb_valid = 0.
- DrawX = 7, DrawY = 95 -> tx = 1, ty = 1, read_address = 161. DrawY = 89 -> valid = 0.
- Drive ram_data_1 = 24'hFF0000 for an in-box pixel -> menu_rgb = 24'h000000 with menu_rgb_valid = 1. Drive ram_data_1 = 24'h9FF5FF -> menu_rgb = 24'h9FF5FF.
- Simulate 61 full frames with (0,0) held for 2 cycles each -> frame_sel = 0 for frames 0–29, 1 for 30–59, and 0 at frame 60. Exactly one count occurs per frame.
- Deassert menu_active while in SHOW_B -> frame_sel = 0 next cycle and menu_rgb_valid = 0 three cycles later. Assert Reset_n low mid-frame -> all outputs are 0 immediately, without waiting for a Clk edge.

Source files
------------

// File: rtl/menu_sprite_fetch.sv
`default_nettype none
// ============================================================================
// Module   : menu_sprite_fetch
// Brief    : Start-menu pixel fetch: raster-to-RAM address, animation frame
//            select and colour keying, 3-cycle latency from DrawX/DrawY.
// Revision : 1.0 - initial release
// ============================================================================
module menu_sprite_fetch #(
   parameter int          IMG_W       = 160,
   parameter int          IMG_H       = 75,
   parameter int          SCALE_SHIFT = 2,
   parameter int          ORIGIN_X    = 0,
   parameter int          ORIGIN_Y    = 90,
   parameter int          FRAME_HOLD  = 30,
   parameter logic [23:0] KEY_COLOR   = 24'hFF0000,
   parameter logic [23:0] BG_COLOR    = 24'h000000
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        menu_active,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   output logic [18:0] read_address,
   output logic        frame_sel,
   input  logic [23:0] ram_data_1,
   input  logic [23:0] ram_data_2,
   output logic [23:0] menu_rgb,
   output logic        menu_rgb_valid
);

   localparam logic [9:0]  c_origin_x  = 10'(ORIGIN_X);
   localparam logic [9:0]  c_origin_y  = 10'(ORIGIN_Y);
   localparam logic [10:0] c_box_w     = 11'(IMG_W << SCALE_SHIFT);
   localparam logic [10:0] c_box_h     = 11'(IMG_H << SCALE_SHIFT);
   localparam logic [7:0]  c_hold_last = 8'(FRAME_HOLD - 1);

   typedef enum logic [0:0] {
      SHOW_A = 1'b0,
      SHOW_B = 1'b1
   } state_t;

   logic [9:0]  w_rel_x;
   logic [9:0]  w_rel_y;
   logic [9:0]  w_tx;
   logic [9:0]  w_ty;
   logic        w_in_box;
   logic [18:0] w_row_base;
   logic [18:0] w_addr;
   logic        w_at_origin;
   logic        w_frame_start;
   logic [23:0] w_selected;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [7:0]  r_hold_cnt;
   logic [7:0]  w_hold_cnt_nxt;
   logic        r_at_origin;
   logic        r_in_box_d1;
   logic        r_in_box_d2;
   logic        r_frame_sel_d1;
   logic        r_frame_sel_d2;

   // Explicit lower-bound compares keep positions left/above the origin from wrapping in.
   assign w_rel_x  = DrawX - c_origin_x;
   assign w_rel_y  = DrawY - c_origin_y;
   assign w_in_box = (DrawX >= c_origin_x) && ({1'b0, w_rel_x} < c_box_w) &&
                     (DrawY >= c_origin_y) && ({1'b0, w_rel_y} < c_box_h) &&
                     menu_active;
   assign w_tx     = w_rel_x >> SCALE_SHIFT;
   assign w_ty     = w_rel_y >> SCALE_SHIFT;

   generate
      if (IMG_W == 160) begin : g_row_shift
         assign w_row_base = ({9'd0, w_ty} << 7) + ({9'd0, w_ty} << 5);
      end else begin : g_row_mult
         assign w_row_base = {9'd0, w_ty} * 19'(IMG_W);
      end
   endgenerate

   assign w_addr = w_row_base + {9'd0, w_tx};

   // Upstream holds (0,0) for two clocks; edge detection counts it once.
   assign w_at_origin   = (DrawX == 10'd0) && (DrawY == 10'd0);
   assign w_frame_start = w_at_origin && !r_at_origin;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state    <= SHOW_A;
         r_hold_cnt <= 8'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_hold_cnt <= w_hold_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_hold_cnt_nxt = r_hold_cnt;
      if (!menu_active) begin
         w_state_nxt    = SHOW_A;
         w_hold_cnt_nxt = 8'd0;
      end else if (w_frame_start) begin
         if (r_hold_cnt == c_hold_last) begin
            w_hold_cnt_nxt = 8'd0;
            w_state_nxt    = (r_state == SHOW_A) ? SHOW_B : SHOW_A;
         end else begin
            w_hold_cnt_nxt = r_hold_cnt + 8'd1;
         end
      end
   end

   assign frame_sel = (r_state == SHOW_B);

   // Frame select travels with the address so RAM data and its source stay paired.
   assign w_selected = r_frame_sel_d2 ? ram_data_2 : ram_data_1;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         read_address   <= 19'd0;
         r_at_origin    <= 1'b0;
         r_in_box_d1    <= 1'b0;
         r_in_box_d2    <= 1'b0;
         r_frame_sel_d1 <= 1'b0;
         r_frame_sel_d2 <= 1'b0;
         menu_rgb       <= 24'd0;
         menu_rgb_valid <= 1'b0;
      end else begin
         read_address   <= w_in_box ? w_addr : 19'd0;
         r_at_origin    <= w_at_origin;
         r_in_box_d1    <= w_in_box;
         r_in_box_d2    <= r_in_box_d1;
         r_frame_sel_d1 <= frame_sel;
         r_frame_sel_d2 <= r_frame_sel_d1;
         menu_rgb       <= (r_in_box_d2 && (w_selected != KEY_COLOR)) ? w_selected : BG_COLOR;
         menu_rgb_valid <= r_in_box_d2;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_menu_sprite_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_menu_sprite_fetch
// Brief    : Self-checking bench for menu_sprite_fetch with a behavioural
//            pixel/animation reference model and a two-RAM memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_menu_sprite_fetch;

   localparam int          IMG_W       = 160;
   localparam int          IMG_H       = 75;
   localparam int          SCALE_SHIFT = 2;
   localparam int          ORIGIN_X    = 0;
   localparam int          ORIGIN_Y    = 90;
   localparam int          FRAME_HOLD  = 30;
   localparam logic [23:0] KEY_COLOR   = 24'hFF0000;
   localparam logic [23:0] BG_COLOR    = 24'h000000;
   localparam int          MEM_DEPTH   = IMG_W * IMG_H;
   localparam int          SCALE       = 2 ** SCALE_SHIFT;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        menu_active = 1'b0;
   logic [9:0]  DrawX = 10'd700;
   logic [9:0]  DrawY = 10'd0;
   logic [18:0] read_address;
   logic        frame_sel;
   logic [23:0] ram_data_1 = 24'd0;
   logic [23:0] ram_data_2 = 24'd0;
   logic [23:0] menu_rgb;
   logic        menu_rgb_valid;

   logic [23:0] mem1 [MEM_DEPTH];
   logic [23:0] mem2 [MEM_DEPTH];

   int checks = 0;
   int passes = 0;

   // Reference model state
   int          mdl_events;
   bit          mdl_prev_origin;
   logic [23:0] pv_rgb [3];
   logic        pv_val [3];
   logic [18:0] exp_addr;
   logic        exp_sel;
   logic [23:0] exp_rgb;
   logic        exp_valid;

   menu_sprite_fetch #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .SCALE_SHIFT(SCALE_SHIFT),
      .ORIGIN_X(ORIGIN_X), .ORIGIN_Y(ORIGIN_Y), .FRAME_HOLD(FRAME_HOLD),
      .KEY_COLOR(KEY_COLOR), .BG_COLOR(BG_COLOR)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .menu_active(menu_active),
      .DrawX(DrawX), .DrawY(DrawY), .read_address(read_address),
      .frame_sel(frame_sel), .ram_data_1(ram_data_1), .ram_data_2(ram_data_2),
      .menu_rgb(menu_rgb), .menu_rgb_valid(menu_rgb_valid)
   );

   always #5 Clk = ~Clk;

   // Synchronous-read frame RAMs
   always @(posedge Clk) begin
      if (int'(read_address) < MEM_DEPTH) begin
         ram_data_1 <= mem1[int'(read_address)];
         ram_data_2 <= mem2[int'(read_address)];
      end else begin
         ram_data_1 <= 24'h0;
         ram_data_2 <= 24'h0;
      end
   end

   task automatic model_reset();
      mdl_events      = 0;
      mdl_prev_origin = 1'b0;
      for (int i = 0; i < 3; i++) begin
         pv_rgb[i] = 24'h0;
         pv_val[i] = 1'b0;
      end
      exp_addr  = 19'd0;
      exp_sel   = 1'b0;
      exp_rgb   = 24'h0;
      exp_valid = 1'b0;
   endtask

   task automatic model_step(input logic [9:0] x, input logic [9:0] y, input logic act);
      int          rx, ry, a;
      bit          inb, sel, org;
      logic [23:0] col, rgb;
      rx  = int'(x) - ORIGIN_X;
      ry  = int'(y) - ORIGIN_Y;
      inb = act && rx >= 0 && rx < IMG_W * SCALE && ry >= 0 && ry < IMG_H * SCALE;
      a   = inb ? (ry / SCALE) * IMG_W + rx / SCALE : 0;
      sel = ((mdl_events / FRAME_HOLD) % 2) == 1;
      col = sel ? mem2[a] : mem1[a];
      rgb = (inb && col != KEY_COLOR) ? col : BG_COLOR;
      pv_rgb[2] = pv_rgb[1]; pv_rgb[1] = pv_rgb[0]; pv_rgb[0] = rgb;
      pv_val[2] = pv_val[1]; pv_val[1] = pv_val[0]; pv_val[0] = inb;
      exp_rgb   = pv_rgb[2];
      exp_valid = pv_val[2];
      exp_addr  = 19'(a);
      org = (x == 10'd0) && (y == 10'd0);
      if (!act) mdl_events = 0;
      else if (org && !mdl_prev_origin) mdl_events++;
      mdl_prev_origin = org;
      exp_sel = ((mdl_events / FRAME_HOLD) % 2) == 1;
   endtask

   task automatic drive_cycle(input logic [9:0] x, input logic [9:0] y, input logic act);
      DrawX = x; DrawY = y; menu_active = act;
      @(posedge Clk);
      model_step(x, y, act);
      @(negedge Clk);
   endtask

   task automatic test_reset();
      Reset_n = 1'b0; menu_active = 1'b1; DrawX = 10'd0; DrawY = 10'd90;
      model_reset();
      repeat (2) @(negedge Clk);
      checks++;
      if ({read_address, frame_sel, menu_rgb, menu_rgb_valid} !== 45'd0)
         $display("FAIL reset_outputs: got %h expected 0", {read_address, frame_sel, menu_rgb, menu_rgb_valid});
      else passes++;
      Reset_n = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         drive_cycle(10'd0, 10'd90, 1'b1);
         checks++;
         if (read_address !== 19'd0) $display("FAIL first_addr c%0d: got %0d expected 0", c, read_address);
         else passes++;
         checks++;
         if (menu_rgb_valid !== (c >= 3)) $display("FAIL first_valid c%0d: got %b expected %b", c, menu_rgb_valid, (c >= 3));
         else passes++;
         checks++;
         if (menu_rgb !== ((c >= 3) ? 24'h123456 : 24'h0))
            $display("FAIL first_rgb c%0d: got %h expected %h", c, menu_rgb, (c >= 3) ? 24'h123456 : 24'h0);
         else passes++;
      end
   endtask

   task automatic test_boundary();
      logic [9:0]  bx [6];
      logic [9:0]  by [6];
      logic [18:0] ba [6];
      bx = '{10'd639, 10'd640, 10'd7, 10'd7, 10'd639, 10'd1023};
      by = '{10'd389, 10'd389, 10'd95, 10'd89, 10'd390, 10'd95};
      ba = '{19'd11999, 19'd0, 19'd161, 19'd0, 19'd0, 19'd0};
      for (int i = 0; i < 6; i++) begin
         for (int h = 0; h < 2; h++) begin
            drive_cycle(bx[i], by[i], 1'b1);
            checks++;
            if (read_address !== ba[i]) $display("FAIL bound_addr (%0d,%0d): got %0d expected %0d", bx[i], by[i], read_address, ba[i]);
            else passes++;
            checks++;
            if (menu_rgb_valid !== exp_valid || menu_rgb !== exp_rgb)
               $display("FAIL bound_rgb (%0d,%0d): got %b/%h expected %b/%h", bx[i], by[i], menu_rgb_valid, menu_rgb, exp_valid, exp_rgb);
            else passes++;
         end
      end
      for (int c = 0; c < 3; c++) begin
         drive_cycle(10'd700, 10'd0, 1'b1);
         checks++;
         if (menu_rgb_valid !== exp_valid || menu_rgb !== exp_rgb)
            $display("FAIL bound_tail c%0d: got %b/%h expected %b/%h", c, menu_rgb_valid, menu_rgb, exp_valid, exp_rgb);
         else passes++;
      end
   endtask

   task automatic test_color_key();
      logic [23:0] vals [2];
      logic [23:0] outs [2];
      vals = '{KEY_COLOR, 24'h9FF5FF};
      outs = '{BG_COLOR, 24'h9FF5FF};
      for (int i = 0; i < 2; i++) begin
         repeat (2) drive_cycle(10'd700, 10'd0, 1'b1);
         mem1[161] = vals[i];
         repeat (3) drive_cycle(10'd7, 10'd95, 1'b1);
         checks++;
         if (menu_rgb_valid !== 1'b1 || menu_rgb !== outs[i])
            $display("FAIL color_key %h: got %b/%h expected 1/%h", vals[i], menu_rgb_valid, menu_rgb, outs[i]);
         else passes++;
      end
   endtask

   task automatic test_random();
      logic [9:0] x, y;
      logic       act;
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 9) < 7) begin
            x = 10'($urandom_range(0, 639));
            y = 10'($urandom_range(90, 389));
         end else begin
            x = 10'($urandom_range(0, 1023));
            y = 10'($urandom_range(0, 524));
         end
         act = ($urandom_range(0, 15) != 0);
         for (int h = 0; h < 2; h++) begin
            drive_cycle(x, y, act);
            checks++;
            if (read_address !== exp_addr) $display("FAIL rnd_addr (%0d,%0d,%b): got %0d expected %0d", x, y, act, read_address, exp_addr);
            else passes++;
            checks++;
            if (frame_sel !== exp_sel) $display("FAIL rnd_sel: got %b expected %b", frame_sel, exp_sel);
            else passes++;
            checks++;
            if (menu_rgb !== exp_rgb) $display("FAIL rnd_rgb: got %h expected %h", menu_rgb, exp_rgb);
            else passes++;
            checks++;
            if (menu_rgb_valid !== exp_valid) $display("FAIL rnd_valid: got %b expected %b", menu_rgb_valid, exp_valid);
            else passes++;
         end
      end
   endtask

   task automatic test_animation();
      logic want;
      drive_cycle(10'd700, 10'd0, 1'b0);
      for (int k = 0; k <= 60; k++) begin
         want = ((k / FRAME_HOLD) % 2) == 1;
         checks++;
         if (frame_sel !== want) $display("FAIL anim_frame%0d: got %b expected %b", k, frame_sel, want);
         else passes++;
         for (int c = 0; c < 5; c++) begin
            if (c < 2) drive_cycle(10'd0, 10'd0, 1'b1);
            else drive_cycle(10'($urandom_range(4, 639)), 10'($urandom_range(90, 389)), 1'b1);
            checks++;
            if (frame_sel !== exp_sel || menu_rgb !== exp_rgb || menu_rgb_valid !== exp_valid)
               $display("FAIL anim_cycle f%0d c%0d: got %b/%h/%b expected %b/%h/%b", k, c,
                        frame_sel, menu_rgb, menu_rgb_valid, exp_sel, exp_rgb, exp_valid);
            else passes++;
         end
      end
      checks++;
      if (frame_sel !== 1'b0) $display("FAIL anim_after61: got %b expected 0", frame_sel);
      else passes++;
   endtask

   task automatic test_deactivate();
      drive_cycle(10'd700, 10'd0, 1'b0);
      for (int k = 0; k < FRAME_HOLD; k++) begin
         repeat (2) drive_cycle(10'd0, 10'd0, 1'b1);
         drive_cycle(10'd8, 10'd100, 1'b1);
      end
      checks++;
      if (frame_sel !== 1'b1) $display("FAIL deact_in_b: got %b expected 1", frame_sel);
      else passes++;
      repeat (2) drive_cycle(10'd8, 10'd100, 1'b1);
      for (int c = 1; c <= 3; c++) begin
         drive_cycle(10'd8, 10'd100, 1'b0);
         checks++;
         if (frame_sel !== 1'b0) $display("FAIL deact_sel c%0d: got %b expected 0", c, frame_sel);
         else passes++;
         checks++;
         if (menu_rgb_valid !== (c < 3)) $display("FAIL deact_valid c%0d: got %b expected %b", c, menu_rgb_valid, (c < 3));
         else passes++;
      end
   endtask

   task automatic test_async_reset();
      mem1[322] = 24'h0A0B0C;
      repeat (3) drive_cycle(10'd8, 10'd100, 1'b1);
      #2;
      Reset_n = 1'b0;
      #1;
      checks++;
      if (read_address !== 19'd0) $display("FAIL areset_addr: got %0d expected 0", read_address);
      else passes++;
      checks++;
      if (frame_sel !== 1'b0) $display("FAIL areset_sel: got %b expected 0", frame_sel);
      else passes++;
      checks++;
      if (menu_rgb !== 24'h0) $display("FAIL areset_rgb: got %h expected 0", menu_rgb);
      else passes++;
      checks++;
      if (menu_rgb_valid !== 1'b0) $display("FAIL areset_valid: got %b expected 0", menu_rgb_valid);
      else passes++;
      model_reset();
      @(negedge Clk);
      Reset_n = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         drive_cycle(10'd8, 10'd100, 1'b1);
         checks++;
         if (read_address !== 19'd322) $display("FAIL arel_addr c%0d: got %0d expected 322", c, read_address);
         else passes++;
         checks++;
         if (menu_rgb_valid !== (c >= 3) || menu_rgb !== ((c >= 3) ? 24'h0A0B0C : 24'h0))
            $display("FAIL arel_rgb c%0d: got %b/%h expected %b/%h", c, menu_rgb_valid, menu_rgb,
                     (c >= 3), (c >= 3) ? 24'h0A0B0C : 24'h0);
         else passes++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
         mem1[i] = ($urandom_range(0, 7) == 0) ? KEY_COLOR : 24'($urandom);
         mem2[i] = ($urandom_range(0, 7) == 0) ? KEY_COLOR : 24'($urandom);
      end
      mem1[0] = 24'h123456;
      test_reset();
      test_boundary();
      test_color_key();
      test_random();
      test_animation();
      test_deactivate();
      test_async_reset();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
